// File: rtl/dual_port_ram.sv
// dual_port_ram: simple dual-port sample store on a single clock.
// Port A reads and writes (read-first); port B is read-only. Both read
// ports are registered and have a latency of one clock. rst clears only the
// output registers; the array keeps its contents across reset.
module dual_port_ram #(
   parameter int ADDR_WIDTH = 19,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic                  enb,
   input  logic                  wea,
   input  logic [ADDR_WIDTH-1:0] addra,
   input  logic [ADDR_WIDTH-1:0] addrb,
   input  logic [DATA_WIDTH-1:0] dia,
   output logic [DATA_WIDTH-1:0] doa,
   output logic [DATA_WIDTH-1:0] dob
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // Every word starts at zero, so never-written locations read as 0 rather than X.
   logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1] = '{default: '0};

   logic [DATA_WIDTH-1:0] r_doa;
   logic [DATA_WIDTH-1:0] r_dob;

   // Port A: optional write plus read-first readout; reset blocks the write and clears doa.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_doa <= '0;
      end else if (ena) begin
         if (wea) begin
            r_mem[addra] <= dia;
         end
         r_doa <= r_mem[addra];
      end
   end

   // Port B: registered read of the pre-edge contents, so a same-address write on A
   // shows up here only from the next enabled read.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dob <= '0;
      end else if (enb) begin
         r_dob <= r_mem[addrb];
      end
   end

   assign doa = r_doa;
   assign dob = r_dob;

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed bench for dual_port_ram: reset behaviour, write/read on both ports,
// read-first on A, A/B collision, enable hold and reset in mid-stream.
module tb_dual_port_ram;

   localparam int AW = 19;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          ena;
   logic          enb;
   logic          wea;
   logic [AW-1:0] addra;
   logic [AW-1:0] addrb;
   logic [DW-1:0] dia;
   logic [DW-1:0] doa;
   logic [DW-1:0] dob;

   int checks = 0;
   int errors = 0;

   dual_port_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .rst   (rst),
      .ena   (ena),
      .enb   (enb),
      .wea   (wea),
      .addra (addra),
      .addrb (addrb),
      .dia   (dia),
      .doa   (doa),
      .dob   (dob)
   );

   // Clock.
   always #5 clk = ~clk;

   // One rising edge, then settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Single port-A write cycle; port B idle.
   task automatic write_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
      ena = 1'b1; wea = 1'b1; addra = a; dia = d; enb = 1'b0;
      tick();
      ena = 1'b0; wea = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ena = 1'b0; enb = 1'b0; wea = 1'b0;
      addra = '0; addrb = '0; dia = '0;

      // Reset with a write attempt at address 5 for two clocks.
      ena = 1'b1; enb = 1'b1; wea = 1'b1; addra = 19'd5; addrb = 19'd5; dia = 16'hDEAD;
      tick();
      tick();
      check("rst_doa", doa, 16'h0000);
      check("rst_dob", dob, 16'h0000);

      // Write during reset must not have landed.
      rst = 1'b0; wea = 1'b0; ena = 1'b1; enb = 1'b1; addra = 19'd5; addrb = 19'd5;
      tick();
      check("rst_suppress_b", dob, 16'h0000);
      check("rst_suppress_a", doa, 16'h0000);

      // Write at lowest and highest address, read back on B.
      write_a(19'd0, 16'h1234);
      write_a(19'h7FFFF, 16'hABCD);
      enb = 1'b1; addrb = 19'd0;
      tick();
      check("rd_b_addr0", dob, 16'h1234);
      addrb = 19'h7FFFF;
      tick();
      check("rd_b_addrmax", dob, 16'hABCD);
      enb = 1'b0;

      // Read-first on A.
      ena = 1'b1; wea = 1'b1; addra = 19'd3; dia = 16'h00AA;
      tick();
      check("rf_first_write", doa, 16'h0000);
      dia = 16'h00BB;
      tick();
      check("rf_second_write", doa, 16'h00AA);
      wea = 1'b0;
      tick();
      check("rf_readback", doa, 16'h00BB);
      ena = 1'b0;

      // Collision: A writes address 7 while B reads it.
      write_a(19'd7, 16'h0001);
      ena = 1'b1; wea = 1'b1; addra = 19'd7; dia = 16'h0002; enb = 1'b1; addrb = 19'd7;
      tick();
      check("coll_old", dob, 16'h0001);
      check("coll_doa_old", doa, 16'h0001);
      ena = 1'b0; wea = 1'b0;
      tick();
      check("coll_new", dob, 16'h0002);

      // Port B enable hold.
      enb = 1'b0;
      addrb = 19'd0;
      tick();
      check("holdb_0", dob, 16'h0002);
      addrb = 19'd3;
      tick();
      check("holdb_1", dob, 16'h0002);
      addrb = 19'h7FFFF;
      tick();
      check("holdb_2", dob, 16'h0002);

      // Port A enable gates the write: ena=0, wea=1 must not store.
      write_a(19'd9, 16'h0055);
      check("wr9_doa_old", doa, 16'h0000);
      ena = 1'b0; wea = 1'b1; addra = 19'd9; dia = 16'hFFFF;
      tick();
      check("holda_doa", doa, 16'h0000);
      ena = 1'b1; wea = 1'b0; enb = 1'b1; addrb = 19'd9;
      tick();
      check("gated_wr_a", doa, 16'h0055);
      check("gated_wr_b", dob, 16'h0055);

      // Reset in mid-stream: fill, make outputs non-zero, pulse rst with a write attempt.
      for (int i = 0; i < 4; i++) write_a(AW'(i), DW'(i + 1));
      ena = 1'b1; wea = 1'b0; addra = 19'd1; enb = 1'b1; addrb = 19'd2;
      tick();
      check("pre_rst_doa", doa, 16'h0002);
      check("pre_rst_dob", dob, 16'h0003);
      rst = 1'b1; wea = 1'b1; addra = 19'd0; dia = 16'hFFFF;
      tick();
      check("mid_rst_doa", doa, 16'h0000);
      check("mid_rst_dob", dob, 16'h0000);
      rst = 1'b0; ena = 1'b0; enb = 1'b0; wea = 1'b0;
      tick();
      check("post_rst_hold_a", doa, 16'h0000);
      check("post_rst_hold_b", dob, 16'h0000);
      ena = 1'b1; enb = 1'b1;
      for (int i = 0; i < 4; i++) begin
         addra = AW'(i);
         addrb = AW'(3 - i);
         tick();
         check($sformatf("post_rst_a%0d", i), doa, DW'(i + 1));
         check($sformatf("post_rst_b%0d", 3 - i), dob, DW'(4 - i));
      end
      ena = 1'b0; enb = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
